// File: rtl/serial_subtractor_32.sv
// -----------------------------------------------------------------------------
// serial_subtractor_32
//
// Multi-cycle 32-bit subtractor: o_diff = i_a - i_b (mod 2^32).
// It processes one SLICE_W-bit slice per clock, least significant slice first.
// The subtraction is done as a + ~b + 1. The "+1" is the initial carry, and
// the carry is chained between slices in a register. A final carry of 0 means
// that a borrow occurred (i_a < i_b, unsigned).
//
// Parameters:
//   SLICE_W    slice width per cycle: 4, 8, 16 or 32 (N_SLICE = 32/SLICE_W)
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_valid    operands valid (sampled only while idle)
//   o_ready    block can accept operands (registered, high in IDLE)
//   i_a, i_b   minuend / subtrahend
//   o_valid    result valid (registered, high in DONE)
//   i_ready    downstream accepts result
//   o_diff     difference, held until the next result
//   o_borrow   1 when i_a < i_b (unsigned)
//   o_overflow signed overflow (only when SUB_OVERFLOW_EN is defined)
//
// Build option: `define SUB_OVERFLOW_EN adds the o_overflow port and its logic.
// -----------------------------------------------------------------------------
module serial_subtractor_32 #(
    parameter int SLICE_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_diff,
    output logic        o_borrow
`ifdef SUB_OVERFLOW_EN
    ,
    output logic        o_overflow
`endif
);

    localparam int N_SLICE = 32 / SLICE_W;
    localparam int CNT_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic [31:0]        diff_q, diff_d;
    logic               borrow_q, borrow_d;
`ifdef SUB_OVERFLOW_EN
    logic               ovf_q, ovf_d;
`endif

    // Operand and working registers carry no reset. They are always written
    // before they are read.
    logic [31:0]        a_q, a_d;
    logic [31:0]        nb_q, nb_d;      // holds ~i_b
    logic [31:0]        res_q, res_d;    // slices of the result under construction

    logic [4:0]         lo;
    logic [SLICE_W-1:0] a_sl, nb_sl;
    logic [SLICE_W:0]   sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        a_d      = a_q;
        nb_d     = nb_q;
        res_d    = res_q;

        lo    = 5'(cnt_q * SLICE_W);
        a_sl  = a_q[lo +: SLICE_W];
        nb_sl = nb_q[lo +: SLICE_W];
        sum   = {1'b0, a_sl} + {1'b0, nb_sl} + {{SLICE_W{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    a_d     = i_a;
                    nb_d    = ~i_b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d[lo +: SLICE_W] = sum[SLICE_W-1:0];
                carry_d              = sum[SLICE_W];
                cnt_d                = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Publish the complete result only now, so the outputs
                    // keep the previous result for the whole computation.
                    cnt_d    = '0;
                    diff_d   = res_d;
                    borrow_d = ~sum[SLICE_W];
`ifdef SUB_OVERFLOW_EN
                    // Operands of different sign, and the result sign differs
                    // from the minuend sign.
                    ovf_d    = (a_q[31] ^ ~nb_q[31]) & (a_q[31] ^ res_d[31]);
`endif
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        a_q   <= a_d;
        nb_q  <= nb_d;
        res_q <= res_d;
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_diff     = diff_q;
    assign o_borrow   = borrow_q;
`ifdef SUB_OVERFLOW_EN
    assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_32.sv
// -----------------------------------------------------------------------------
// Bench for serial_subtractor_32. A main instance runs at the default slice
// width, and three more instances run at SLICE_W = 4, 16 and 32. Expected
// results come from plain 32/64-bit arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_valid, i_ready;
    logic [31:0] i_a, i_b;
    logic        o_ready, o_valid, o_borrow;
    logic [31:0] o_diff;
`ifdef SUB_OVERFLOW_EN
    logic        o_ovf;
`endif

    serial_subtractor_32 dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_diff(o_diff), .o_borrow(o_borrow)
`ifdef SUB_OVERFLOW_EN
        , .o_overflow(o_ovf)
`endif
    );

    // Instances with other slice widths share one input set.
    logic        w_valid, w_ready;
    logic [31:0] w_a, w_b;
    logic        rdy4, vld4, bor4, rdy16, vld16, bor16, rdy32, vld32, bor32;
    logic [31:0] d4, d16, d32;
`ifdef SUB_OVERFLOW_EN
    logic        ovf4, ovf16, ovf32;
`endif

    serial_subtractor_32 #(.SLICE_W(4)) u4 (
        .i_clk(clk), .i_rst(rst), .i_valid(w_valid), .o_ready(rdy4),
        .i_a(w_a), .i_b(w_b), .o_valid(vld4), .i_ready(w_ready),
        .o_diff(d4), .o_borrow(bor4)
`ifdef SUB_OVERFLOW_EN
        , .o_overflow(ovf4)
`endif
    );
    serial_subtractor_32 #(.SLICE_W(16)) u16 (
        .i_clk(clk), .i_rst(rst), .i_valid(w_valid), .o_ready(rdy16),
        .i_a(w_a), .i_b(w_b), .o_valid(vld16), .i_ready(w_ready),
        .o_diff(d16), .o_borrow(bor16)
`ifdef SUB_OVERFLOW_EN
        , .o_overflow(ovf16)
`endif
    );
    serial_subtractor_32 #(.SLICE_W(32)) u32 (
        .i_clk(clk), .i_rst(rst), .i_valid(w_valid), .o_ready(rdy32),
        .i_a(w_a), .i_b(w_b), .o_valid(vld32), .i_ready(w_ready),
        .o_diff(d32), .o_borrow(bor32)
`ifdef SUB_OVERFLOW_EN
        , .o_overflow(ovf32)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_diff(input logic [31:0] a, input logic [31:0] b);
        return a - b;
    endfunction

    function automatic logic exp_borrow(input logic [31:0] a, input logic [31:0] b);
        return (a < b);
    endfunction

    function automatic logic exp_ovf(input logic [31:0] a, input logic [31:0] b);
        longint sd;
        sd = longint'($signed(a)) - longint'($signed(b));
        return (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    endfunction

    // This task drives one operation on the main instance, which must be idle,
    // with i_ready high. It returns the latency and the captured outputs and
    // ends one edge after the handshake.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] d, output logic br);
        i_a = a; i_b = b; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = -1; d = '0; br = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (o_valid === 1'b1) begin
                lat = k; d = o_diff; br = o_borrow;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_a = '0; i_b = '0;
        w_valid = 1'b0; w_ready = 1'b1; w_a = '0; w_b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++; if (o_diff !== 32'h0) begin n_fail++; $display("FAIL reset_diff: got %h want 0", o_diff); end
        n_checks++; if (o_borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b want 0", o_borrow); end
`ifdef SUB_OVERFLOW_EN
        n_checks++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o_ovf); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0)
            begin n_fail++; $display("FAIL post_reset_idle: ready=%b valid=%b want 1/0", o_ready, o_valid); end
    endtask

    task automatic test_directed();
        logic [31:0] av[6] = '{32'h0000_0005, 32'h0000_0000, 32'h0100_0000,
                               32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv[6] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001,
                               32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int lat; logic [31:0] d; logic br;
        for (int i = 0; i < 6; i++) begin
            do_op(av[i], bv[i], lat, d, br);
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d want 4", i, lat); end
            n_checks++; if (d !== exp_diff(av[i], bv[i]))
                begin n_fail++; $display("FAIL dir_diff[%0d]: got %h want %h", i, d, exp_diff(av[i], bv[i])); end
            n_checks++; if (br !== exp_borrow(av[i], bv[i]))
                begin n_fail++; $display("FAIL dir_borrow[%0d]: got %b want %b", i, br, exp_borrow(av[i], bv[i])); end
            n_checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0)
                begin n_fail++; $display("FAIL dir_handshake[%0d]: ready=%b valid=%b want 1/0", i, o_ready, o_valid); end
`ifdef SUB_OVERFLOW_EN
            n_checks++; if (o_ovf !== exp_ovf(av[i], bv[i]))
                begin n_fail++; $display("FAIL dir_ovf[%0d]: got %b want %b", i, o_ovf, exp_ovf(av[i], bv[i])); end
`endif
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] a, b, d; logic br;
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom;
            if (i % 4 == 0) b = a + 32'($urandom_range(0, 2)) - 32'd1;
            do_op(a, b, lat, d, br);
            n_checks++; if (lat !== 4 || d !== exp_diff(a, b) || br !== exp_borrow(a, b))
                begin n_fail++; $display("FAIL rand[%0d] %h-%h: lat=%0d diff=%h br=%b want 4 %h %b",
                                         i, a, b, lat, d, br, exp_diff(a, b), exp_borrow(a, b)); end
`ifdef SUB_OVERFLOW_EN
            n_checks++; if (o_ovf !== exp_ovf(a, b))
                begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, o_ovf, exp_ovf(a, b)); end
`endif
        end
    endtask

    // Continuous i_valid and i_ready: one result every N+2 = 6 cycles.
    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        want;
        a = $urandom; b = $urandom;
        i_a = a; i_b = b; i_valid = 1'b1; i_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            want = (k == 4) || (k == 10) || (k == 16);
            n_checks++; if (o_valid !== want)
                begin n_fail++; $display("FAIL b2b_valid[k=%0d]: got %b want %b", k, o_valid, want); end
            if (want) begin
                n_checks++; if (o_diff !== exp_diff(a, b))
                    begin n_fail++; $display("FAIL b2b_diff[k=%0d]: got %h want %h", k, o_diff, exp_diff(a, b)); end
            end
        end
        i_valid = 1'b0;
        for (int k = 0; k < 20 && !(o_ready === 1'b1 && o_valid === 1'b0); k++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (o_ready !== 1'b1)
            begin n_fail++; $display("FAIL b2b_drain: ready=%b want 1", o_ready); end
    endtask

    task automatic test_backpressure();
        logic [31:0] aa, ab, ba, bb;
        int lat;
        aa = 32'h9000_0000; ab = 32'h1234_5678;
        ba = 32'h0BAD_F00D; bb = 32'h0000_1234;
        i_ready = 1'b0;
        i_a = aa; i_b = ab; i_valid = 1'b1;
        @(posedge clk); #1;
        i_a = ba; i_b = bb;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (o_valid === 1'b1) begin lat = k; break; end
        end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d want 4", lat); end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_diff !== exp_diff(aa, ab) || o_borrow !== exp_borrow(aa, ab)) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b diff=%h br=%b want 1 0 %h %b",
                         k, o_valid, o_ready, o_diff, o_borrow, exp_diff(aa, ab), exp_borrow(aa, ab));
            end
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1)
            begin n_fail++; $display("FAIL bp_release: valid=%b ready=%b want 0 1", o_valid, o_ready); end
        @(posedge clk); #1;
        i_valid = 1'b0;
        n_checks++; if (o_ready !== 1'b0)
            begin n_fail++; $display("FAIL bp_accept_next: ready=%b want 0", o_ready); end
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (o_valid === 1'b1) begin lat = k; break; end
        end
        n_checks++; if (lat !== 4 || o_diff !== exp_diff(ba, bb) || o_borrow !== exp_borrow(ba, bb))
            begin n_fail++; $display("FAIL bp_next_result: lat=%0d diff=%h br=%b want 4 %h %b",
                                     lat, o_diff, o_borrow, exp_diff(ba, bb), exp_borrow(ba, bb)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] d; logic br;
        i_a = 32'hFFFF_FFFF; i_b = 32'h1234_5678; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", o_ready); end
        n_checks++; if (o_diff !== 32'h0) begin n_fail++; $display("FAIL midrst_diff: got %h want 0", o_diff); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            n_checks++; if (o_valid !== 1'b0)
                begin n_fail++; $display("FAIL midrst_no_result[%0d]: valid=%b want 0", k, o_valid); end
        end
        do_op(32'h0000_0010, 32'h0000_0010, lat, d, br);
        n_checks++; if (lat !== 4 || d !== 32'h0 || br !== 1'b0)
            begin n_fail++; $display("FAIL midrst_fresh: lat=%0d diff=%h br=%b want 4 0 0", lat, d, br); end
    endtask

    task automatic test_slice_widths();
        logic [31:0] a, b;
        int lat4, lat16, lat32, c4, c16, c32;
        logic [31:0] cd4, cd16, cd32;
        logic cb4, cb16, cb32;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin a = 32'h0100_0000; b = 32'h0000_0001; end
            else if (i == 1) begin a = 32'h0000_0000; b = 32'h0000_0001; end
            else begin a = $urandom; b = $urandom; end
            w_a = a; w_b = b; w_valid = 1'b1;
            @(posedge clk); #1;
            w_valid = 1'b0;
            lat4 = -1; lat16 = -1; lat32 = -1; c4 = 0; c16 = 0; c32 = 0;
            cd4 = '0; cd16 = '0; cd32 = '0; cb4 = 0; cb16 = 0; cb32 = 0;
            for (int k = 1; k <= 14; k++) begin
                @(posedge clk); #1;
                if (vld4 === 1'b1) begin c4++; if (lat4 < 0) begin lat4 = k; cd4 = d4; cb4 = bor4; end end
                if (vld16 === 1'b1) begin c16++; if (lat16 < 0) begin lat16 = k; cd16 = d16; cb16 = bor16; end end
                if (vld32 === 1'b1) begin c32++; if (lat32 < 0) begin lat32 = k; cd32 = d32; cb32 = bor32; end end
            end
            n_checks++; if (lat4 !== 8 || c4 !== 1 || cd4 !== exp_diff(a, b) || cb4 !== exp_borrow(a, b))
                begin n_fail++; $display("FAIL sw4[%0d]: lat=%0d cnt=%0d diff=%h br=%b want 8 1 %h %b",
                                         i, lat4, c4, cd4, cb4, exp_diff(a, b), exp_borrow(a, b)); end
            n_checks++; if (lat16 !== 2 || c16 !== 1 || cd16 !== exp_diff(a, b) || cb16 !== exp_borrow(a, b))
                begin n_fail++; $display("FAIL sw16[%0d]: lat=%0d cnt=%0d diff=%h br=%b want 2 1 %h %b",
                                         i, lat16, c16, cd16, cb16, exp_diff(a, b), exp_borrow(a, b)); end
            n_checks++; if (lat32 !== 1 || c32 !== 1 || cd32 !== exp_diff(a, b) || cb32 !== exp_borrow(a, b))
                begin n_fail++; $display("FAIL sw32[%0d]: lat=%0d cnt=%0d diff=%h br=%b want 1 1 %h %b",
                                         i, lat32, c32, cd32, cb32, exp_diff(a, b), exp_borrow(a, b)); end
            n_checks++; if (rdy4 !== 1'b1 || rdy16 !== 1'b1 || rdy32 !== 1'b1)
                begin n_fail++; $display("FAIL sw_idle[%0d]: ready=%b%b%b want 111", i, rdy4, rdy16, rdy32); end
`ifdef SUB_OVERFLOW_EN
            n_checks++; if (ovf4 !== exp_ovf(a, b) || ovf16 !== exp_ovf(a, b) || ovf32 !== exp_ovf(a, b))
                begin n_fail++; $display("FAIL sw_ovf[%0d]: got %b%b%b want %b", i, ovf4, ovf16, ovf32, exp_ovf(a, b)); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_slice_widths();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/serial_subtractor_32.md
# serial_subtractor_32

Multi-cycle 32-bit unsigned/two's-complement subtractor computing o_diff = i_a − i_b. It processes one SLICE_W-bit slice per clock, least significant slice first, and chains the borrow between slices in a carry register. It is the inverse-direction companion to the 32-bit adder datapath. It has a valid/ready handshake on both sides so it can sit between pipeline stages of the arithmetic unit.

## Interface
- SLICE_W, 8, slice width processed per cycle; legal values 4, 8, 16, 32; N_SLICE = 32/SLICE_W
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  operands valid
- o_ready  output  1  block can accept operands
- i_a  input  32  minuend
- i_b  input  32  subtrahend
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_diff  output  32  difference, i_a − i_b mod 2^32
- o_borrow  output  1  1 when i_a < i_b (unsigned)
- o_overflow  output  1  signed overflow; present only with SUB_OVERFLOW_EN

## Operation
- FSM states:
  - IDLE: o_ready=1
  - CALC: slice counter cnt runs 0..N_SLICE−1
  - DONE: o_valid=1
- IDLE→CALC on an edge with i_valid && o_ready. i_a and ~i_b are latched into operand registers. The carry register is set to 1 and cnt to 0.
- Each CALC cycle computes {carry, o_diff[cnt*SLICE_W +: SLICE_W]} = a_slice + ~b_slice + carry, then increments cnt.
- CALC→DONE on the edge that processes slice N_SLICE−1. At that edge o_borrow = ~final_carry.
- DONE→IDLE on an edge with i_ready=1. o_diff, o_borrow and o_overflow hold their values until the next DONE.
- i_valid is ignored outside IDLE.
- o_diff is don't-care while o_valid=0. o_diff, o_borrow and o_overflow are stable for the whole of DONE.
- Reset values: state IDLE, cnt 0, carry 0, o_ready 1, o_valid 0, o_diff 0, o_borrow 0, o_overflow 0.
- Reset asserted in any state aborts the operation immediately. No result is produced and the block returns to IDLE.

## Timing
- Acceptance edge E0. Slices are computed on edges E1..E_N, with N = N_SLICE (4 at default).
- o_valid rises after E_N, so latency is N cycles from acceptance to valid.
- With i_ready held high, o_valid is high for exactly 1 cycle. The result handshake occurs at E_N+1, and o_ready is high after E_N+1.
- Earliest next acceptance is E_N+2, giving one operation per N+2 cycles.
- With i_ready low, DONE is held indefinitely and o_ready stays 0.
- SLICE_W=32: CALC lasts 1 cycle; latency 1.

## Configuration
- SUB_OVERFLOW_EN defined:
  - o_overflow port exists.
  - Set in DONE to (a[31]^b[31]) & (a[31]^diff[31]), using the latched operands.
  - Cleared on reset.
- SUB_OVERFLOW_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Basic subtract: reset, then i_a=0x0000_0005, i_b=0x0000_0003, i_ready=1.
  - o_valid exactly 4 cycles after acceptance.
  - o_diff=0x0000_0002, o_borrow=0, o_overflow=0.
- Unsigned underflow: i_a=0x0000_0000, i_b=0x0000_0001 -> o_diff=0xFFFF_FFFF, o_borrow=1.
- Borrow across slice boundary: i_a=0x0100_0000, i_b=0x0000_0001 -> o_diff=0x00FF_FFFF, o_borrow=0. Repeat with SLICE_W=4 and SLICE_W=16; latency is 8 and 2 cycles respectively.
- Signed overflow (SUB_OVERFLOW_EN): i_a=0x8000_0000, i_b=0x0000_0001 -> o_diff=0x7FFF_FFFF, o_overflow=1, o_borrow=0.
- Backpressure:
  - Hold i_ready=0 for 10 cycles after o_valid, and drive i_valid=1 with new operands the whole time.
  - Required: o_valid, o_diff and o_borrow are stable, o_ready=0, and the new operands are not accepted.
  - Raise i_ready: the handshake completes, then o_ready=1 and the new operands are accepted one cycle later.
- Reset mid-operation: assert i_rst during the 2nd CALC cycle of 0xFFFF_FFFF−0x1234_5678.
  - Immediately: o_valid=0, o_ready=1, o_diff=0.
  - After release: a fresh 0x0000_0010−0x0000_0010 returns 0x0000_0000 with o_borrow=0.
